// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: line, configuration, sampler feedback and status signals of the UART RX sequencer.
interface uart_rx_ctrl_if #(parameter int PRESCALE_W = 6);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  start_bit;
    logic                  stop_bit;
    logic                  par_err;
    logic [3:0]            BIT_COUNT;
    logic [PRESCALE_W-1:0] edge_count;
    logic                  sample_window;
    logic                  sample_one_bit;
    logic                  sample_three_bit;
    logic                  data_valid;
    logic                  parity_error;
    logic                  frame_error;
    logic                  busy;
    modport master (
        output RX_IN, PAR_EN, Prescale, start_bit, stop_bit, par_err,
        input  BIT_COUNT, edge_count, sample_window, sample_one_bit, sample_three_bit,
               data_valid, parity_error, frame_error, busy
    );
    modport slave (
        input  RX_IN, PAR_EN, Prescale, start_bit, stop_bit, par_err,
        output BIT_COUNT, edge_count, sample_window, sample_one_bit, sample_three_bit,
               data_valid, parity_error, frame_error, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX sequencer - start detect, oversampling/bit counters, sample strobes, frame result pulses.
module uart_rx_ctrl #(
    parameter int PRESCALE_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state, state_nx;
    logic [3:0]            bit_cnt, bit_nx;
    logic [PRESCALE_W-1:0] edge_cnt, p, p_in, half;
    logic                  pe, eob, stop_eob, active;
    logic                  dv_q, perr_q, ferr_q;
    // Unsupported oversampling ratios fall back to the single-sample rate.
    assign p_in     = (bus.Prescale == PRESCALE_W'(16) || bus.Prescale == PRESCALE_W'(32)) ? bus.Prescale : PRESCALE_W'(8);
    assign half     = p >> 1;
    assign eob      = edge_cnt == p - PRESCALE_W'(1);
    assign stop_eob = state == STOP && eob;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            edge_cnt <= '0;
            p        <= PRESCALE_W'(8);
            pe       <= 1'b0;
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_nx;
            edge_cnt <= (state == IDLE || eob) ? '0 : edge_cnt + PRESCALE_W'(1);
            if (state == IDLE && !bus.RX_IN) begin
                p  <= p_in;
                pe <= bus.PAR_EN;
            end
            dv_q     <= stop_eob && bus.stop_bit && !(pe && bus.par_err);
            perr_q   <= stop_eob && pe && bus.par_err;
            ferr_q   <= stop_eob && !bus.stop_bit;
        end
    end
    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        unique case (state)
            IDLE: begin
                bit_nx   = '0;
                state_nx = bus.RX_IN ? IDLE : START;
            end
            START: if (eob) begin
                state_nx = bus.start_bit ? IDLE : DATA;
                bit_nx   = bus.start_bit ? 4'd0 : 4'd1;
            end
            DATA: if (eob) begin
                bit_nx   = bit_cnt + 4'd1;
                state_nx = bit_cnt != 4'd8 ? DATA : pe ? PARITY : STOP;
            end
            PARITY: if (eob) begin
                bit_nx   = 4'd10;
                state_nx = STOP;
            end
            STOP: if (eob) begin
                bit_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                bit_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end
    always_comb begin
        active               = state != IDLE;
        bus.busy             = active;
        bus.BIT_COUNT        = bit_cnt;
        bus.edge_count       = edge_cnt;
        bus.sample_window    = active && (edge_cnt == half - PRESCALE_W'(1) || edge_cnt == half || edge_cnt == half + PRESCALE_W'(1));
        bus.sample_one_bit   = active && p == PRESCALE_W'(8) && edge_cnt == half;
        bus.sample_three_bit = active && p != PRESCALE_W'(8) && edge_cnt == half + PRESCALE_W'(1);
        bus.data_valid       = dv_q;
        bus.parity_error     = perr_q;
        bus.frame_error      = ferr_q;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames with a result scoreboard; the monitor checks pulses and strobes as the DUT emits them.
module tb_uart_rx_ctrl;
    localparam int W = 6;
    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_p = 8;
    exp_t q[$];
    uart_rx_ctrl_if #(.PRESCALE_W(W)) bus();
    uart_rx_ctrl #(.PRESCALE_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic logic [16:0] all_out();
        return {bus.BIT_COUNT, bus.edge_count, bus.sample_window, bus.sample_one_bit, bus.sample_three_bit,
                bus.data_valid, bus.parity_error, bus.frame_error, bus.busy};
    endfunction
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bus.data_valid || bus.parity_error || bus.frame_error) begin
                if (q.size() == 0) chk("unexpected_pulse", {bus.data_valid, bus.parity_error, bus.frame_error}, 0);
                else begin
                    e = q.pop_front();
                    chk("result_flags", {bus.data_valid, bus.parity_error, bus.frame_error}, e.flags);
                    chk("result_cycle", cyc, e.cyc);
                end
            end
            if (bus.sample_one_bit) begin
                chk("one_bit_edge", bus.edge_count, exp_p / 2);
                chk("one_bit_window", bus.sample_window, 1);
            end
            if (bus.sample_three_bit) begin
                chk("three_bit_edge", bus.edge_count, exp_p / 2 + 1);
                chk("three_bit_window", bus.sample_window, 1);
            end
        end
    end
    // Called at a negedge; returns at the negedge where the result pulse is visible.
    task automatic frame(input int pin, input bit pen, input logic [7:0] data, input bit perr, input bit stp,
                         input int pmid, input int lat, input logic [2:0] flags);
        int p, n, s, ones, threes;
        p = (pin == 16 || pin == 32) ? pin : 8;
        n = pen ? 11 : 10;
        bus.Prescale = W'(pin); bus.PAR_EN = pen; bus.start_bit = 1'b0;
        bus.stop_bit = stp; bus.par_err = perr; bus.RX_IN = 1'b0; exp_p = p;
        @(negedge clk);
        s = cyc;
        q.push_back('{flags, s + lat});
        bus.Prescale = W'(pmid);
        bus.PAR_EN = ~pen;
        ones = 0; threes = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < p; k++) begin
                if (k == 0) bus.RX_IN = b == 0 ? 1'b0 : b <= 8 ? data[b-1] : (pen && b == 9) ? ^data : 1'b1;
                if (k == p / 2) chk("bit_count", bus.BIT_COUNT, b);
                ones += int'(bus.sample_one_bit);
                threes += int'(bus.sample_three_bit);
                @(negedge clk);
            end
        end
        bus.RX_IN = 1'b1;
        chk("strobe_count", p == 8 ? ones : threes, n);
        chk("other_strobe", p == 8 ? threes : ones, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int s;
        bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = W'(16);
        bus.start_bit = 1'b0; bus.stop_bit = 1'b1; bus.par_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_out(), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        frame(16, 1'b0, 8'hA5, 1'b0, 1'b1, 16, 160, 3'b100);
        frame(8, 1'b1, 8'h3C, 1'b0, 1'b1, 8, 88, 3'b100);
        frame(32, 1'b1, 8'h5A, 1'b1, 1'b1, 32, 352, 3'b010);
        chk("idle_after_perr", {bus.busy, bus.BIT_COUNT}, 0);
        // Start glitch: line low for three clocks, sampled start bit reads 1.
        bus.Prescale = W'(16); bus.start_bit = 1'b1; bus.RX_IN = 1'b0; exp_p = 16;
        @(negedge clk);
        s = cyc;
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (13) @(negedge clk);
        chk("glitch_edge15", {bus.busy, 2'b00, bus.edge_count}, 9'h10F);
        @(negedge clk);
        chk("glitch_idle", {bus.busy, bus.BIT_COUNT, bus.edge_count}, 0);
        chk("glitch_cycle", cyc - s, 16);
        repeat (3) @(negedge clk);
        frame(16, 1'b0, 8'h81, 1'b0, 1'b1, 16, 160, 3'b100);
        frame(16, 1'b0, 8'hFF, 1'b0, 1'b0, 16, 160, 3'b001);
        frame(16, 1'b0, 8'h12, 1'b0, 1'b1, 8, 160, 3'b100);
        frame(8, 1'b0, 8'h34, 1'b0, 1'b1, 8, 80, 3'b100);
        // Reset in the middle of data bit 5.
        bus.Prescale = W'(16); bus.PAR_EN = 1'b0; bus.start_bit = 1'b0; bus.RX_IN = 1'b0; exp_p = 16;
        repeat (1 + 5 * 16 + 8) @(negedge clk);
        chk("pre_reset_bit", bus.BIT_COUNT, 5);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 0);
        bus.RX_IN = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", {bus.busy, bus.BIT_COUNT, bus.edge_count}, 0);
        frame(8, 1'b0, 8'h55, 1'b0, 1'b1, 8, 80, 3'b100);
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX datapath.
- Detects the start edge on RX_IN and runs the oversampling edge counter and the bit counter.
- Issues the sample strobes and BIT_COUNT that steer the sampled-data register and sampler.
- Evaluates start, parity and stop results and reports data_valid or errors per frame.

Parameters:
- PRESCALE_W, 6, width of the Prescale input; legal latched values are 8, 16 and 32.

Ports:
- clk  input  1  system clock (oversampled, Prescale x baud)
- rst_n  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, idle high
- PAR_EN  input  1  parity bit present in frame
- Prescale  input  PRESCALE_W  clocks per bit
- start_bit  input  1  sampled start bit from the sampled-data register
- stop_bit  input  1  sampled stop bit from the sampled-data register
- par_err  input  1  parity checker result, combinational from the register contents
- BIT_COUNT  output  4  index of the bit currently being received (0 = start, 1-8 = data, 9 = parity or stop, 10 = stop)
- edge_count  output  PRESCALE_W  clock index within the current bit
- sample_window  output  1  high while edge_count is P/2-1, P/2 or P/2+1 (sampler shift enable)
- sample_one_bit  output  1  single-sample strobe (P = 8)
- sample_three_bit  output  1  majority-sample strobe (P = 16 or 32)
- data_valid  output  1  one-cycle pulse: frame good, data ready
- parity_error  output  1  one-cycle pulse at frame end
- frame_error  output  1  one-cycle pulse at frame end (bad stop bit)
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, any state, including mid-frame): state = IDLE; BIT_COUNT = 0; edge_count = 0; all strobes and pulses = 0; latched P = 8; latched PAR_EN = 0.
- Reset release: no frame is started until RX_IN is seen low while in IDLE.
- States: IDLE, START, DATA, PARITY, STOP.
- Configuration latch:
  - On the IDLE-to-START transition, Prescale is latched as P and PAR_EN as PE.
  - Both hold for the whole frame; input changes mid-frame are ignored.
  - A Prescale value other than 8, 16 or 32 latches as 8.
- Edge counter:
  - Counts 0 to P-1 every clk in all non-IDLE states, then wraps to 0.
  - "End of bit" (EOB) is the cycle with edge_count = P-1.
- IDLE:
  - Counters are held at 0.
  - RX_IN = 0 for one cycle: go to START with edge_count = 0 on the next cycle.
- Strobes:
  - sample_one_bit = 1 for one cycle when P = 8 and edge_count = P/2.
  - sample_three_bit = 1 for one cycle when P is 16 or 32 and edge_count = P/2+1.
  - Strobes are asserted only in START, DATA, PARITY and STOP.
  - The register captures on the following edge, so start_bit, stop_bit and par_err are stable by EOB.
- START at EOB:
  - start_bit = 1 (glitch): go to IDLE, BIT_COUNT = 0, no error pulse.
  - Otherwise: go to DATA, BIT_COUNT = 1.
- DATA at EOB:
  - BIT_COUNT < 8: increment BIT_COUNT.
  - BIT_COUNT = 8: BIT_COUNT = 9; go to PARITY if PE, else to STOP.
- PARITY at EOB: BIT_COUNT = 10; go to STOP.
- STOP at EOB: evaluate, assert the result on the next cycle, then go to IDLE with BIT_COUNT = 0.
  - frame_error = !stop_bit.
  - parity_error = PE & par_err.
  - data_valid = stop_bit & !(PE & par_err).
  - Exactly one of data_valid or the error pulse(s) fires per completed frame; parity_error and frame_error may fire together.
- Back-to-back frames: the cycle after STOP EOB the block is in IDLE; RX_IN = 0 there starts the next frame with no dead bit required.
- Break condition: a line held low restarts a frame each time IDLE is re-entered, and each such frame reports frame_error.
- busy is combinational from state.
- Output timing: BIT_COUNT and edge_count are registered; strobes are decoded from registered state and count, with no combinational path from RX_IN.

Test Plan:
- P=16, PAR_EN=0, byte 0xA5, stop=1 -> BIT_COUNT steps 0..9; one sample_three_bit per bit at edge 9; data_valid pulses once 160 clks after start detect; no errors.
- P=8, PAR_EN=1, byte 0x3C with even parity correct -> sample_one_bit at edge 4 of each bit; BIT_COUNT reaches 10; data_valid 88 clks after start detect.
- P=32, PAR_EN=1, par_err forced 1 at STOP -> parity_error pulse only, data_valid = 0; return to IDLE with BIT_COUNT = 0.
- Start glitch: RX_IN low 3 clks then high (P=16, start_bit samples 1) -> back to IDLE at edge 15 of START, busy drops, no pulses; the next valid frame is received normally.
- Stop bit = 0 with PAR_EN=0 -> frame_error pulse, data_valid = 0.
- Back-to-back frames with Prescale changed 16->8 mid-frame -> first frame uses P=16, second uses P=8.
- rst_n asserted mid-DATA (BIT_COUNT=5) -> all outputs 0 immediately; after release the block waits in IDLE for a new start.
